// File: rtl/buzzer_front_end.sv
`default_nettype none
// ============================================================================
//  Module   : buzzer_front_end
//  Purpose  : Input conditioner for the quiz core. Synchronises and debounces
//             the four team buttons and the judge "correct" button, produces
//             one-cycle rise events, arbitrates the first buzz while the
//             window is armed and hands the winner to the core over req/ack.
//  Ports    : clk            - system clock
//             master_reset_n - asynchronous active-low reset
//             btn_team[3:0]  - raw team buttons (bit0=A .. bit3=D)
//             btn_correct    - raw judge button
//             arm            - buzzer window open (from core)
//             lock_ack       - core accepts the current team_req
//             team_req       - team_onehot is valid
//             team_onehot    - winning team, one-hot
//             correct_pulse  - one-cycle pulse per debounced judge press
//             btn_level[4:0] - debounced levels {correct, D, C, B, A}
//             late_press     - sticky: team pressed while window was locked
//  Revision : 1.0 - initial release
// ============================================================================
module buzzer_front_end #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic       clk,
  input  logic       master_reset_n,
  input  logic [3:0] btn_team,
  input  logic       btn_correct,
  input  logic       arm,
  input  logic       lock_ack,
  output logic       team_req,
  output logic [3:0] team_onehot,
  output logic       correct_pulse,
  output logic [4:0] btn_level,
  output logic [3:0] late_press
);

  localparam int               C_NCH      = 5;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OPEN   = 2'd1,
    ST_REQ    = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  // Channel order {correct, D, C, B, A} matches btn_level.
  logic [C_NCH-1:0] w_raw;
  logic [C_NCH-1:0] sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q [C_NCH];
  logic [CNT_W-1:0] cnt_d [C_NCH];
  logic [C_NCH-1:0] stable_q, stable_d;
  logic [C_NCH-1:0] stable_dly_q;
  logic [C_NCH-1:0] rise_q;

  state_t     state_q, state_d;
  logic       team_req_q, team_req_d;
  logic [3:0] onehot_q, onehot_d;
  logic [3:0] late_q, late_d;
  logic [3:0] w_team_rise;
  logic [3:0] w_pick;

  assign w_raw = {btn_correct, btn_team};

  // Debounce: the counter measures how long the synchronised input has
  // disagreed with the stable level; any agreement restarts the measurement.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < C_NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == C_CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + C_CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge master_reset_n) begin
    if (!master_reset_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      rise_q       <= '0;
      for (int i = 0; i < C_NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q      <= w_raw;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      rise_q       <= stable_q & ~stable_dly_q;
      for (int i = 0; i < C_NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign w_team_rise = rise_q[3:0];
  // Isolate the lowest set bit: A (bit0) has the highest priority.
  assign w_pick      = w_team_rise & (~w_team_rise + 4'd1);

  always_comb begin
    state_d    = state_q;
    team_req_d = team_req_q;
    onehot_d   = onehot_q;
    late_d     = late_q;
    case (state_q)
      ST_IDLE: begin
        team_req_d = 1'b0;
        onehot_d   = '0;
        if (arm) begin
          state_d = ST_OPEN;
          late_d  = '0;
        end
      end
      ST_OPEN: begin
        // A closed window overrides a coincident rise.
        if (!arm) begin
          state_d = ST_IDLE;
        end else if (|w_team_rise) begin
          onehot_d   = w_pick;
          team_req_d = 1'b1;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (lock_ack) begin
          state_d    = ST_LOCKED;
          team_req_d = 1'b0;
        end else if (!arm) begin
          state_d    = ST_IDLE;
          team_req_d = 1'b0;
          onehot_d   = '0;
        end
      end
      ST_LOCKED: begin
        if (!arm) begin
          state_d  = ST_IDLE;
          onehot_d = '0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        team_req_d = 1'b0;
        onehot_d   = '0;
      end
    endcase
    // Applied after the clear above so a set in the same cycle wins.
    if (state_q == ST_REQ || state_q == ST_LOCKED) begin
      late_d = late_d | w_team_rise;
    end
  end

  always_ff @(posedge clk or negedge master_reset_n) begin
    if (!master_reset_n) begin
      state_q    <= ST_IDLE;
      team_req_q <= 1'b0;
      onehot_q   <= '0;
      late_q     <= '0;
    end else begin
      state_q    <= state_d;
      team_req_q <= team_req_d;
      onehot_q   <= onehot_d;
      late_q     <= late_d;
    end
  end

  assign team_req      = team_req_q;
  assign team_onehot   = onehot_q;
  assign correct_pulse = rise_q[4];
  assign btn_level     = stable_q;
  assign late_press    = late_q;

endmodule
`default_nettype wire

// File: tb/tb_buzzer_front_end.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_buzzer_front_end
//  Purpose  : Self-checking bench for buzzer_front_end with a scoreboard fed
//             by a behavioural model and directed plus random stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_buzzer_front_end;

  localparam int C_DEB = 4;
  localparam int C_CW  = 3;

  logic       clk;
  logic       rst_n;
  logic [3:0] bt;
  logic       bc;
  logic       arm;
  logic       ack;
  logic       team_req;
  logic [3:0] team_onehot;
  logic       correct_pulse;
  logic [4:0] btn_level;
  logic [3:0] late_press;

  int errors = 0;
  int checks = 0;

  buzzer_front_end #(.DEBOUNCE_CYCLES(C_DEB), .CNT_W(C_CW)) dut (
    .clk           (clk),
    .master_reset_n(rst_n),
    .btn_team      (bt),
    .btn_correct   (bc),
    .arm           (arm),
    .lock_ack      (ack),
    .team_req      (team_req),
    .team_onehot   (team_onehot),
    .correct_pulse (correct_pulse),
    .btn_level     (btn_level),
    .late_press    (late_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // A button level reaches the debouncer two edges after it is sampled and
  // must then disagree with the accepted level for C_DEB consecutive edges.
  localparam int M_IDLE = 0, M_OPEN = 1, M_REQ = 2, M_LOCKED = 3;
  logic [4:0] m_seen1, m_seen2;
  int         m_run [5];
  logic [4:0] m_stab;
  logic [4:0] m_up_prev;
  logic [4:0] m_rise;
  int         m_mode;
  logic       m_req;
  logic [3:0] m_win;
  logic [3:0] m_late;

  logic [14:0] exp_q [$];

  task automatic model_reset();
    m_seen1 = '0; m_seen2 = '0; m_stab = '0; m_up_prev = '0; m_rise = '0;
    for (int i = 0; i < 5; i++) m_run[i] = 0;
    m_mode = M_IDLE; m_req = 1'b0; m_win = '0; m_late = '0;
  endtask

  function automatic logic [3:0] first_team(input logic [3:0] r);
    logic [3:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      if (r[i] && w == 4'd0) w[i] = 1'b1;
    end
    return w;
  endfunction

  task automatic model_edge(input logic [4:0] raw, input logic a, input logic k);
    logic [4:0] seen;
    logic [4:0] up;
    logic [3:0] tr;
    int         old_mode;
    seen = m_seen2; m_seen2 = m_seen1; m_seen1 = raw;
    up = '0;
    for (int ch = 0; ch < 5; ch++) begin
      if (seen[ch] != m_stab[ch]) begin
        m_run[ch]++;
        if (m_run[ch] == C_DEB) begin
          m_stab[ch] = seen[ch];
          m_run[ch]  = 0;
          up[ch]     = seen[ch];
        end
      end else begin
        m_run[ch] = 0;
      end
    end
    tr = m_rise[3:0];
    old_mode = m_mode;
    case (old_mode)
      M_IDLE:   if (a) begin m_mode = M_OPEN; m_late = '0; end
      M_OPEN: begin
        if (!a) m_mode = M_IDLE;
        else if (tr != 4'd0) begin m_mode = M_REQ; m_req = 1'b1; m_win = first_team(tr); end
      end
      M_REQ: begin
        if (k) begin m_mode = M_LOCKED; m_req = 1'b0; end
        else if (!a) begin m_mode = M_IDLE; m_req = 1'b0; m_win = '0; end
      end
      default: if (!a) begin m_mode = M_IDLE; m_win = '0; end
    endcase
    if (old_mode == M_REQ || old_mode == M_LOCKED) m_late = m_late | tr;
    m_rise = m_up_prev;
    m_up_prev = up;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each cycle the DUT presents its output word; pop and compare.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        logic [14:0] e;
        e = exp_q.pop_front();
        chk("outputs{req,onehot,cpulse,level,late}",
            {17'd0, team_req, team_onehot, correct_pulse, btn_level, late_press},
            {17'd0, e});
      end
    end
  end

  // One clock: DUT and model both consume the current inputs at the edge.
  task automatic cycle();
    @(posedge clk);
    model_edge({bc, bt}, arm, ack);
    exp_q.push_back({m_req, m_win, m_rise[4], m_stab, m_late});
    @(negedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    bt = '0; bc = 1'b0; ack = 1'b0; arm = 1'b0;
    repeat (n) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int pulses;
  int first_idx;
  int hold [5];

  initial begin
    bt = '0; bc = 1'b0; arm = 1'b0; ack = 1'b0;
    rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs", {17'd0, team_req, team_onehot, correct_pulse, btn_level, late_press}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // 1: single press, latency and handshake
    arm = 1'b1; bt = 4'b0001;
    repeat (7) cycle();
    chk("t1_req_not_before_edge7", {31'd0, team_req}, 32'd0);
    cycle();
    chk("t1_req_after_edge7", {31'd0, team_req}, 32'd1);
    chk("t1_onehot", {28'd0, team_onehot}, 32'h1);
    repeat (3) cycle();
    chk("t1_req_held", {31'd0, team_req}, 32'd1);
    ack = 1'b1; cycle(); ack = 1'b0;
    chk("t1_req_dropped_on_ack", {31'd0, team_req}, 32'd0);
    settle(12);

    // 2: glitch rejection, then minimum-length pulse
    arm = 1'b1; cycle();
    bt = 4'b0010; repeat (3) cycle(); bt = 4'b0000;
    repeat (10) cycle();
    chk("t2_glitch_level", {31'd0, btn_level[1]}, 32'd0);
    chk("t2_glitch_no_req", {31'd0, team_req}, 32'd0);
    bt = 4'b0010; repeat (4) cycle(); bt = 4'b0000;
    cycle();
    chk("t2_level_low_after_edge4", {31'd0, btn_level[1]}, 32'd0);
    cycle();
    chk("t2_level_high_after_edge5", {31'd0, btn_level[1]}, 32'd1);
    settle(12);

    // 3: simultaneous rise, late press, clear on re-arm
    arm = 1'b1; cycle();
    bt = 4'b1100; repeat (8) cycle();
    chk("t3_winner_C", {28'd0, team_onehot}, 32'h4);
    chk("t3_req", {31'd0, team_req}, 32'd1);
    chk("t3_no_late_for_loser", {28'd0, late_press}, 32'h0);
    ack = 1'b1; cycle(); ack = 1'b0;
    bt = 4'b0000; repeat (10) cycle();
    bt = 4'b1000; repeat (10) cycle();
    chk("t3_late_D", {28'd0, late_press}, 32'h8);
    arm = 1'b0; repeat (2) cycle();
    arm = 1'b1; cycle();
    chk("t3_late_cleared", {28'd0, late_press}, 32'h0);
    settle(12);

    // 4: abort in REQ, then ack beats arm drop
    arm = 1'b1; cycle();
    bt = 4'b0001; repeat (8) cycle();
    arm = 1'b0; cycle();
    chk("t4_abort_req", {31'd0, team_req}, 32'd0);
    chk("t4_abort_onehot", {28'd0, team_onehot}, 32'h0);
    settle(12);
    arm = 1'b1; cycle();
    bt = 4'b0010; repeat (8) cycle();
    ack = 1'b1; arm = 1'b0; cycle(); ack = 1'b0;
    chk("t4_ack_wins_onehot", {28'd0, team_onehot}, 32'h2);
    chk("t4_ack_wins_req", {31'd0, team_req}, 32'd0);
    settle(12);

    // 5: judge button, one pulse per press
    for (int p = 0; p < 2; p++) begin
      bc = 1'b1; pulses = 0; first_idx = -1;
      for (int i = 0; i < 20; i++) begin
        cycle();
        if (correct_pulse === 1'b1) begin
          pulses++;
          if (first_idx < 0) first_idx = i;
        end
      end
      chk("t5_pulse_count", pulses, 32'd1);
      chk("t5_pulse_edge", first_idx, 32'd6);
      bc = 1'b0; repeat (12) cycle();
    end

    // 6: asynchronous reset while LOCKED
    settle(12);
    arm = 1'b1; cycle();
    bt = 4'b0001; repeat (8) cycle();
    ack = 1'b1; cycle(); ack = 1'b0;
    cycle();
    chk("t6_locked_onehot", {28'd0, team_onehot}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_reset_outputs", {17'd0, team_req, team_onehot, correct_pulse, btn_level, late_press}, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    arm = 1'b0;
    repeat (12) cycle();
    arm = 1'b1;
    repeat (10) cycle();
    chk("t6_held_button_no_req", {31'd0, team_req}, 32'd0);
    bt = 4'b0000; repeat (8) cycle();
    bt = 4'b0001; repeat (8) cycle();
    chk("t6_new_rise_req", {31'd0, team_req}, 32'd1);
    settle(12);

    // Random phase: mixed glitches and real presses, random arm and ack.
    for (int i = 0; i < 5; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 5; i++) begin
        if (hold[i] == 0) begin
          logic v;
          v = 1'($urandom_range(0, 1));
          if (i < 4) bt[i] = v; else bc = v;
          hold[i] = int'($urandom_range(1, 12));
        end else begin
          hold[i]--;
        end
      end
      if ($urandom_range(0, 39) == 0) arm = ~arm;
      ack = m_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      cycle();
    end

    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/buzzer_front_end.md
Name: buzzer_front_end

Overview:
Input-side conditioner for the quiz core. It synchronises and debounces the four raw team buzzer buttons and the judge's "correct" button, and produces one-cycle press events. It arbitrates the first valid buzz while the core has the buzzer window armed, and hands the winning team to the core over a req/ack handshake. Together with the core's display side, this block closes the button-to-display path.

Parameters:
DEBOUNCE_CYCLES, 100000, consecutive cycles a synchronised input must differ from its stable level before the stable level changes (10 ms at 10 MHz); legal range 2..2^CNT_W-1.
CNT_W, 17, debounce counter width.

Ports:
clk  input  1  system clock, 10 MHz.
master_reset_n  input  1  asynchronous active-low reset.
btn_team  input  4  raw team buttons, active high; bit0=A, bit1=B, bit2=C, bit3=D.
btn_correct  input  1  raw judge button, active high.
arm  input  1  from the core; high = buzzer window open.
lock_ack  input  1  from the core; accepts the current team_req.
team_req  output  1  valid for team_onehot.
team_onehot  output  4  winning team, one-hot; 0 when team_req is low.
correct_pulse  output  1  one-cycle pulse on each debounced press of btn_correct.
btn_level  output  5  debounced levels {correct, D, C, B, A}.
late_press  output  4  sticky flags: a team pressed while the window was locked.

Behaviour:
- Clock and reset: one clock, reset is asynchronous and active-low (clk, master_reset_n). All flops clear on reset assertion.
- Outputs under reset: team_req=0, team_onehot=0, correct_pulse=0, btn_level=0, late_press=0. FSM enters IDLE.
- Synchroniser: 2-FF chain per input, reset to 0.
- Debounce, per channel:
  - Counter cleared whenever sync == stable.
  - Counter increments on each cycle where sync != stable.
  - When counter == DEBOUNCE_CYCLES-1 and sync still differs: stable <= sync, counter <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
  - Release is debounced identically.
- Rise event: registered pulse on the cycle after stable goes 0->1. Latency: a raw input first sampled high at edge 0 and held produces its rise pulse in the cycle after edge DEBOUNCE_CYCLES+2.
- correct_pulse: the rise event of the correct channel, unconditional and independent of the FSM.
- FSM:
  - IDLE: arm=0. Team rises are ignored. arm=1 -> OPEN.
  - OPEN: on any team rise, load team_onehot with the highest-priority rising team (A>B>C>D) and set team_req=1 at the same edge -> REQ. arm=0 -> IDLE.
  - REQ: team_req and team_onehot are held stable.
    - lock_ack=1 -> LOCKED, team_req=0 at that edge; team_onehot stays held.
    - arm=0 with no ack -> IDLE, team_req=0, team_onehot=0 (abort).
    - lock_ack and arm=0 in the same cycle: ack wins -> LOCKED.
  - LOCKED: team_onehot held. arm=0 -> IDLE, team_onehot=0.
- Simultaneous rises in OPEN: exactly one team wins by priority. The losers set no late_press bit.
- late_press[i]: set on a team-i rise while in REQ or LOCKED. Clears when the FSM enters OPEN. Set takes precedence over clear in the same cycle.
- Rise events occurring in IDLE are discarded and never queued.
- Mid-operation reset: immediate return to IDLE and reset values, regardless of handshake state.

Test Plan:
Test bench uses DEBOUNCE_CYCLES=4.
1. Reset, arm=1, btn_team=0001 held from edge 0 -> team_req=1 and team_onehot=0001 after edge 7; held until lock_ack=1; team_req=0 on the next edge.
2. arm=1, btn_team 0010 glitch lasting 3 cycles -> no team_req; btn_level[1] stays 0. Repeat with a 4-cycle pulse -> btn_level[1] rises after edge 5.
3. arm=1, btn_team=1100 rising on the same edge -> team_onehot=0100, team_req=1. After ack, press D -> late_press=1000. Drop arm, re-arm -> late_press=0000.
4. In REQ with no ack, drop arm -> team_req=0 and team_onehot=0 on the next edge. Then assert lock_ack together with arm=0 in REQ -> LOCKED, team_onehot retained.
5. btn_correct held high for 20 cycles with arm=0 -> exactly one correct_pulse, in the cycle after edge 6. Release and press again -> second pulse.
6. master_reset_n low while in LOCKED with team_onehot=0001 -> all outputs 0 immediately (asynchronous). After release, the FSM is in IDLE and a held button produces no team_req until arm=1 and a new rise occurs.
